// File: rtl/pwm_sequencer.sv
// pwm_sequencer: power-up / run / shutdown / fault sequencer for the DPWM datapath.
// Owns the DPWM enable and duty count and the FreqConverter and dead-time settings.
// Ramps the duty count up on start and down on stop. Setting changes are applied
// only at DPWM period boundaries.
//
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   start              level request to run the converter
//   fault              level fault indication (highest priority)
//   fault_clr          pulse acknowledging a latched fault
//   period_end         pulse from DPWM on counter wrap
//   duty_req/freq_req/dt1_req/dt2_req   requested settings
//   pwm_en/duty_cmd/freq_cmd/dt1_cmd/dt2_cmd   registered commands to the datapath
//   ss_active          high in SOFTSTART or STOPPING
//   fault_latched      sticky fault flag
//   state              IDLE=0 SOFTSTART=1 RUN=2 STOPPING=3 FAULT=4
//
// Optional build macro PWM_WATCHDOG_EN: when pwm_en is high, a missing period_end for
// WDOG_CYCLES clocks is treated as a fault.
module pwm_sequencer #(
  parameter int unsigned DUTY_W       = 10,
  parameter int unsigned RAMP_STEP    = 1,
  parameter int unsigned RAMP_PERIODS = 4,
  parameter int unsigned WDOG_CYCLES  = 2048
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              fault,
  input  logic              fault_clr,
  input  logic              period_end,
  input  logic [DUTY_W-1:0] duty_req,
  input  logic [3:0]        freq_req,
  input  logic [2:0]        dt1_req,
  input  logic [2:0]        dt2_req,
  output logic              pwm_en,
  output logic [DUTY_W-1:0] duty_cmd,
  output logic [3:0]        freq_cmd,
  output logic [2:0]        dt1_cmd,
  output logic [2:0]        dt2_cmd,
  output logic              ss_active,
  output logic              fault_latched,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StSoftStart = 3'd1,
    StRun       = 3'd2,
    StStopping  = 3'd3,
    StFault     = 3'd4
  } state_e;

  localparam int unsigned     PcntW    = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam logic [PcntW-1:0] PcntLast = PcntW'(RAMP_PERIODS - 1);
  localparam logic [DUTY_W:0]  StepExt  = (DUTY_W + 1)'(RAMP_STEP);

  state_e            state_q, state_d;
  logic              pwm_en_q, pwm_en_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] target_q, target_d;
  logic [3:0]        freq_q, freq_d;
  logic [2:0]        dt1_q, dt1_d;
  logic [2:0]        dt2_q, dt2_d;
  logic [PcntW-1:0]  pcnt_q, pcnt_d;
  logic              fault_q, fault_d;
  logic              ss_q;
  logic              wdog_trip;

  // Ramp arithmetic in DUTY_W+1 bits so the up-step cannot wrap.
  logic [DUTY_W:0]   duty_up;
  logic [DUTY_W-1:0] duty_up_sat, duty_dn_sat;

  assign duty_up     = {1'b0, duty_q} + StepExt;
  assign duty_up_sat = (duty_up > {1'b0, target_q}) ? target_q : duty_up[DUTY_W-1:0];
  assign duty_dn_sat = ({1'b0, duty_q} > StepExt) ? (duty_q - DUTY_W'(RAMP_STEP)) : '0;

`ifdef PWM_WATCHDOG_EN
  localparam int unsigned WdogW = $clog2(WDOG_CYCLES + 1);
  logic [WdogW-1:0] wdog_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wdog_q <= '0;
    end else if (!pwm_en_q || period_end) begin
      wdog_q <= '0;
    end else if (!wdog_trip) begin
      wdog_q <= wdog_q + WdogW'(1);
    end
  end

  assign wdog_trip = pwm_en_q && !period_end && (wdog_q == WdogW'(WDOG_CYCLES - 1));
`else
  logic unused_wdog_cfg;
  assign unused_wdog_cfg = ^WDOG_CYCLES;
  assign wdog_trip       = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    pwm_en_d = pwm_en_q;
    duty_d   = duty_q;
    target_d = target_q;
    freq_d   = freq_q;
    dt1_d    = dt1_q;
    dt2_d    = dt2_q;
    pcnt_d   = pcnt_q;
    fault_d  = fault_q;

    if (fault || wdog_trip) begin
      state_d  = StFault;
      pwm_en_d = 1'b0;
      duty_d   = '0;
      fault_d  = 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          pwm_en_d = 1'b0;
          duty_d   = '0;
          if (start && !fault_q) begin
            freq_d   = freq_req;
            dt1_d    = dt1_req;
            dt2_d    = dt2_req;
            target_d = duty_req;
            pcnt_d   = '0;
            pwm_en_d = 1'b1;
            state_d  = StSoftStart;
          end
        end
        StSoftStart: begin
          if (!start) begin
            // Stop request pre-empts any ramp step due this cycle.
            state_d = StStopping;
            pcnt_d  = '0;
          end else if (period_end) begin
            if (duty_q == target_q) begin
              state_d = StRun;
              pcnt_d  = '0;
            end else if (pcnt_q == PcntLast) begin
              pcnt_d = '0;
              duty_d = duty_up_sat;
            end else begin
              pcnt_d = pcnt_q + PcntW'(1);
            end
          end
        end
        StRun: begin
          if (!start) begin
            state_d = StStopping;
            pcnt_d  = '0;
          end else if (period_end) begin
            duty_d = duty_req;
            freq_d = freq_req;
            dt1_d  = dt1_req;
            dt2_d  = dt2_req;
          end
        end
        StStopping: begin
          if (start) begin
            // Resume ramping up from wherever the ramp-down got to.
            state_d  = StSoftStart;
            target_d = duty_req;
            pcnt_d   = '0;
          end else if (period_end) begin
            if (duty_q == '0) begin
              state_d  = StIdle;
              pwm_en_d = 1'b0;
            end else if (pcnt_q == PcntLast) begin
              pcnt_d = '0;
              duty_d = duty_dn_sat;
            end else begin
              pcnt_d = pcnt_q + PcntW'(1);
            end
          end
        end
        StFault: begin
          pwm_en_d = 1'b0;
          duty_d   = '0;
          // fault is known low here; clear is only honoured with start released.
          if (fault_clr && !start) begin
            state_d = StIdle;
            fault_d = 1'b0;
          end
        end
        default: begin
          state_d  = StIdle;
          pwm_en_d = 1'b0;
          duty_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= StIdle;
      pwm_en_q <= 1'b0;
      duty_q   <= '0;
      target_q <= '0;
      freq_q   <= 4'b0110;
      dt1_q    <= 3'b001;
      dt2_q    <= 3'b001;
      pcnt_q   <= '0;
      fault_q  <= 1'b0;
      ss_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pwm_en_q <= pwm_en_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      freq_q   <= freq_d;
      dt1_q    <= dt1_d;
      dt2_q    <= dt2_d;
      pcnt_q   <= pcnt_d;
      fault_q  <= fault_d;
      ss_q     <= (state_d == StSoftStart) || (state_d == StStopping);
    end
  end

  assign pwm_en        = pwm_en_q;
  assign duty_cmd      = duty_q;
  assign freq_cmd      = freq_q;
  assign dt1_cmd       = dt1_q;
  assign dt2_cmd       = dt2_q;
  assign ss_active     = ss_q;
  assign fault_latched = fault_q;
  assign state         = state_q;

endmodule

// File: tb/tb_pwm_sequencer.sv
// Testbench for pwm_sequencer: table-driven vectors for reset and fault handling, plus
// hand-written ramp, run-update, stop/restart, mid-ramp reset and watchdog sequences.
// Expected outputs are queued per cycle and compared one clock later, 1ns after the edge.
`timescale 1ns/1ps
module tb_pwm_sequencer;

  localparam int unsigned DUTY_W = 10;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SS   = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_STOP = 3'd3;
  localparam logic [2:0] S_FLT  = 3'd4;

  typedef struct packed {
    logic [2:0]        state;
    logic              pwm_en;
    logic [DUTY_W-1:0] duty;
    logic [3:0]        freq;
    logic [2:0]        dt1;
    logic [2:0]        dt2;
    logic              ss;
    logic              fl;
  } exp_t;

  typedef struct {
    logic resetn;
    logic start;
    logic fault;
    logic fault_clr;
    logic period_end;
    exp_t exp;
  } vec_t;

  logic              clk;
  logic              resetn;
  logic              start;
  logic              fault;
  logic              fault_clr;
  logic              period_end;
  logic [DUTY_W-1:0] duty_req;
  logic [3:0]        freq_req;
  logic [2:0]        dt1_req;
  logic [2:0]        dt2_req;
  logic              pwm_en;
  logic [DUTY_W-1:0] duty_cmd;
  logic [3:0]        freq_cmd;
  logic [2:0]        dt1_cmd;
  logic [2:0]        dt2_cmd;
  logic              ss_active;
  logic              fault_latched;
  logic [2:0]        state;

  pwm_sequencer #(
    .DUTY_W      (DUTY_W),
    .RAMP_STEP   (1),
    .RAMP_PERIODS(2),
    .WDOG_CYCLES (16)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .fault        (fault),
    .fault_clr    (fault_clr),
    .period_end   (period_end),
    .duty_req     (duty_req),
    .freq_req     (freq_req),
    .dt1_req      (dt1_req),
    .dt2_req      (dt2_req),
    .pwm_en       (pwm_en),
    .duty_cmd     (duty_cmd),
    .freq_cmd     (freq_cmd),
    .dt1_cmd      (dt1_cmd),
    .dt2_cmd      (dt2_cmd),
    .ss_active    (ss_active),
    .fault_latched(fault_latched),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    n_cycle  = 0;
  string tag      = "boot";
  exp_t  ex;
  exp_t  exp_q[$];
  vec_t  boot_tbl[5];
  vec_t  flt_tbl[6];

  function automatic exp_t mk(input logic [2:0] st, input logic en, input int duty,
                              input logic [3:0] fr, input logic [2:0] d1, input logic [2:0] d2,
                              input logic ss, input logic fl);
    exp_t e;
    e.state = st; e.pwm_en = en; e.duty = DUTY_W'(duty); e.freq = fr;
    e.dt1 = d1; e.dt2 = d2; e.ss = ss; e.fl = fl;
    return e;
  endfunction

  function automatic vec_t mv(input logic rn, input logic st, input logic f, input logic fc,
                              input logic pe, input exp_t e);
    vec_t v;
    v.resetn = rn; v.start = st; v.fault = f; v.fault_clr = fc; v.period_end = pe; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s cycle %0d: got %0h, expected %0h", tag, name, n_cycle, act, req);
    end
  endtask

  // Queue the expectation for this edge, clock, then compare against the popped entry.
  task automatic tick();
    exp_t e;
    exp_q.push_back(ex);
    @(posedge clk);
    #1;
    n_cycle++;
    e = exp_q.pop_front();
    chk("state",         32'(state),         32'(e.state));
    chk("pwm_en",        32'(pwm_en),        32'(e.pwm_en));
    chk("duty_cmd",      32'(duty_cmd),      32'(e.duty));
    chk("freq_cmd",      32'(freq_cmd),      32'(e.freq));
    chk("dt1_cmd",       32'(dt1_cmd),       32'(e.dt1));
    chk("dt2_cmd",       32'(dt2_cmd),       32'(e.dt2));
    chk("ss_active",     32'(ss_active),     32'(e.ss));
    chk("fault_latched", 32'(fault_latched), 32'(e.fl));
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pe_tick();
    period_end = 1'b1;
    tick();
    period_end = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v);
    resetn = v.resetn; start = v.start; fault = v.fault;
    fault_clr = v.fault_clr; period_end = v.period_end;
    ex = v.exp;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end of the test");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t rst_e, flt_e, idle_e;
    resetn = 1'b0; start = 1'b0; fault = 1'b0; fault_clr = 1'b0; period_end = 1'b0;
    duty_req = 5; freq_req = 4'b0110; dt1_req = 3'd3; dt2_req = 3'd5;

    rst_e = mk(S_IDLE, 0, 0, 4'b0110, 3'd1, 3'd1, 0, 0);
    boot_tbl[0] = mv(0, 0, 0, 0, 0, rst_e);
    boot_tbl[1] = mv(0, 1, 0, 0, 1, rst_e);
    boot_tbl[2] = mv(1, 0, 0, 0, 1, rst_e);
    boot_tbl[3] = mv(1, 0, 0, 1, 0, rst_e);
    boot_tbl[4] = mv(1, 1, 0, 0, 0, mk(S_SS, 1, 0, 4'b0110, 3'd3, 3'd5, 1, 0));

    flt_e  = mk(S_FLT, 0, 0, 4'b0110, 3'd6, 3'd5, 0, 1);
    idle_e = mk(S_IDLE, 0, 0, 4'b0110, 3'd6, 3'd5, 0, 0);
    flt_tbl[0] = mv(1, 1, 1, 0, 1, flt_e);
    flt_tbl[1] = mv(1, 1, 0, 1, 0, flt_e);
    flt_tbl[2] = mv(1, 0, 1, 1, 0, flt_e);
    flt_tbl[3] = mv(1, 0, 0, 0, 0, flt_e);
    flt_tbl[4] = mv(1, 0, 0, 1, 0, idle_e);
    flt_tbl[5] = mv(1, 0, 0, 0, 0, idle_e);

    // Reset, idle and start.
    for (int i = 0; i < 5; i++) apply_vec(boot_tbl[i]);

    // Soft-start 0 -> 5, one step per two periods, RUN on the following period_end.
    tag = "ramp_up";
    for (int k = 1; k <= 10; k++) begin
      quiet(9);
      ex.duty = DUTY_W'(k / 2);
      pe_tick();
    end
    quiet(9);
    ex.state = S_RUN; ex.ss = 1'b0;
    pe_tick();

    // Settings changed mid-period only land on the next period_end, all together.
    tag = "run_upd";
    quiet(3);
    duty_req = 8; freq_req = 4'b0111; dt1_req = 3'd6;
    quiet(6);
    ex.duty = 8; ex.freq = 4'b0111; ex.dt1 = 3'd6;
    pe_tick();
    quiet(4);
    duty_req = 5; freq_req = 4'b0110;
    quiet(5);
    ex.duty = 5; ex.freq = 4'b0110;
    pe_tick();

    // Stop, ramp down to 3, then restart from 3.
    tag = "stop_restart";
    quiet(4);
    start = 1'b0; ex.state = S_STOP; ex.ss = 1'b1;
    tick();
    for (int k = 1; k <= 4; k++) begin
      quiet(k == 1 ? 4 : 9);
      ex.duty = DUTY_W'(5 - k / 2);
      pe_tick();
    end
    quiet(3);
    start = 1'b1; ex.state = S_SS;
    tick();
    for (int k = 1; k <= 4; k++) begin
      quiet(k == 1 ? 5 : 9);
      ex.duty = DUTY_W'(3 + k / 2);
      pe_tick();
    end
    quiet(9);
    ex.state = S_RUN; ex.ss = 1'b0;
    pe_tick();

    // Full stop down to IDLE.
    tag = "stop_full";
    quiet(4);
    start = 1'b0; ex.state = S_STOP; ex.ss = 1'b1;
    tick();
    for (int k = 1; k <= 10; k++) begin
      quiet(k == 1 ? 4 : 9);
      ex.duty = DUTY_W'(5 - k / 2);
      pe_tick();
    end
    quiet(9);
    ex.state = S_IDLE; ex.pwm_en = 1'b0; ex.ss = 1'b0;
    pe_tick();
    quiet(3);

    // Fault during soft-start with coincident period_end, then clear handling.
    tag = "fault";
    start = 1'b1;
    ex = mk(S_SS, 1, 0, 4'b0110, 3'd6, 3'd5, 1, 0);
    tick();
    quiet(9);
    pe_tick();
    quiet(9);
    ex.duty = 1;
    pe_tick();
    quiet(4);
    for (int i = 0; i < 6; i++) apply_vec(flt_tbl[i]);

    // Reset mid-soft-start returns all outputs to reset values on that edge.
    tag = "rst_mid";
    freq_req = 4'b1010; dt1_req = 3'd7; dt2_req = 3'd2; duty_req = 1;
    start = 1'b1;
    ex = mk(S_SS, 1, 0, 4'b1010, 3'd7, 3'd2, 1, 0);
    tick();
    quiet(9);
    pe_tick();
    quiet(9);
    ex.duty = 1;
    pe_tick();
    quiet(3);
    resetn = 1'b0; ex = rst_e;
    tick();
    resetn = 1'b1;
    ex = mk(S_SS, 1, 0, 4'b1010, 3'd7, 3'd2, 1, 0);
    tick();
    quiet(8);
    pe_tick();
    quiet(9);
    ex.duty = 1;
    pe_tick();
    quiet(9);
    ex.state = S_RUN; ex.ss = 1'b0;
    pe_tick();

    // Stalled DPWM in RUN.
    tag = "wdog";
`ifdef PWM_WATCHDOG_EN
    quiet(15);
    ex = mk(S_FLT, 0, 0, 4'b1010, 3'd7, 3'd2, 0, 1);
    tick();
    quiet(2);
`else
    quiet(40);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_sequencer.md
Name: pwm_sequencer

Overview:
Controls the DPWM/dead-time datapath across power-up, run, shutdown and fault.
- Decides when the DPWM is enabled and what duty count it receives, including soft-start ramp up and soft-stop ramp down.
- Holds frequency-code and dead-time settings in shadow registers and applies them only at DPWM period boundaries.
- Sits between the user/config inputs and the DPWM, FreqConverter and dead-time shift blocks; owns their EN and setting inputs.

Parameters:
DUTY_W, 10, width of duty counts (matches DPWM maxcount/duty width)
RAMP_STEP, 1, duty counts added or removed per ramp step
RAMP_PERIODS, 4, DPWM periods per ramp step (>=1)
WDOG_CYCLES, 2048, clk cycles allowed between period_end pulses (watchdog feature only)

Ports:
clk  in  1  system clock
resetn  in  1  synchronous, active-low reset
start  in  1  level; 1 = request converter running
fault  in  1  level; out-of-bounds/overcurrent indication
fault_clr  in  1  single-cycle pulse; acknowledge a latched fault
period_end  in  1  single-cycle pulse from DPWM when its counter wraps to 0
duty_req  in  DUTY_W  target duty count
freq_req  in  4  target frequency code
dt1_req  in  3  dead-time code, switch 1
dt2_req  in  3  dead-time code, switch 2
pwm_en  out  1  DPWM enable
duty_cmd  out  DUTY_W  duty count to DPWM
freq_cmd  out  4  frequency code to FreqConverter
dt1_cmd  out  3  dead-time code to shifter 1
dt2_cmd  out  3  dead-time code to shifter 2
ss_active  out  1  1 while in SOFTSTART or STOPPING
fault_latched  out  1  sticky fault flag
state  out  3  current state encoding

Behaviour:
- Clocking and reset: one clock, synchronous active-low reset; all outputs are registered.
- Reset values: state=IDLE, pwm_en=0, duty_cmd=0, freq_cmd=4'b0110, dt1_cmd=dt2_cmd=3'b001, ss_active=0, fault_latched=0. The period counter and target register also clear.
- State encoding: IDLE=0, SOFTSTART=1, RUN=2, STOPPING=3, FAULT=4.
- Fault priority: fault=1 in any state wins over all other events. On the next edge: state=FAULT, pwm_en=0, duty_cmd=0, fault_latched=1.
- IDLE: pwm_en=0, duty_cmd=0. When start=1 and fault_latched=0:
  - capture freq_req, dt1_req, dt2_req into the cmd outputs and duty_req into target;
  - clear the period counter; enter SOFTSTART with pwm_en=1 on the same edge.
- SOFTSTART:
  - Each period_end increments the period counter.
  - When the counter is at RAMP_PERIODS-1 and period_end=1: clear the counter and set duty_cmd=min(duty_cmd+RAMP_STEP, target). The sum is computed in DUTY_W+1 bits, so there is no wrap.
  - Enter RUN on the period_end where duty_cmd already equals target. target=0 therefore reaches RUN on the first period_end.
  - start=0 moves to STOPPING next edge, with no step that cycle, even if period_end is also 1.
- RUN: on each period_end, duty_cmd, freq_cmd, dt1_cmd and dt2_cmd load from their _req inputs together in one cycle; they are unchanged between boundaries. start=0 moves to STOPPING next edge.
- STOPPING:
  - Same cadence as SOFTSTART: duty_cmd=max(duty_cmd-RAMP_STEP, 0) every RAMP_PERIODS periods.
  - On a period_end with duty_cmd=0, go to IDLE with pwm_en=0.
  - start=1 during STOPPING goes to SOFTSTART from the current duty_cmd, with target reloaded from duty_req.
- FAULT: pwm_en=0, duty_cmd=0.
  - Exit to IDLE only when fault_clr=1, fault=0 and start=0; this also clears fault_latched.
  - fault_clr while start=1 or fault=1 is ignored.
- ss_active=1 exactly while state is SOFTSTART or STOPPING.
- Latency: all input-to-output responses take one clk edge; setting changes wait for the next period_end.
- resetn=0 mid-ramp or in FAULT returns everything to the reset values on that edge.

Optional Feature:
PWM_WATCHDOG_EN
- Defined: a counter clears on each period_end and counts clk cycles while pwm_en=1. Reaching WDOG_CYCLES with no period_end is treated exactly as fault=1: FAULT entry, fault_latched=1.
- The counter holds at 0 while pwm_en=0.
- Undefined: no watchdog logic; a stalled DPWM never causes a fault.

Test Plan:
- Bench parameters: RAMP_STEP=1, RAMP_PERIODS=2, duty_req=5, period_end every 10 clk, start=1. Required: duty_cmd steps 0→1→2→3→4→5, one step per 2 period_end pulses. The RUN transition happens on the period_end after duty_cmd reaches 5. pwm_en goes 1 one edge after start.
- In RUN, change duty_req 5→8 and freq_req 0110→0111 mid-period. Both outputs stay at 5/0110 until the next period_end, then update in the same cycle.
- In RUN with duty_cmd=5, set start=0. Required: STOPPING, ramp 5→0 at 2 periods/step, then IDLE with pwm_en=0. Reasserting start at duty_cmd=3 returns to SOFTSTART, ramping up from 3.
- In SOFTSTART, assert fault and period_end in the same cycle. Next edge: state=4, pwm_en=0, duty_cmd=0, fault_latched=1. Then fault_clr with start=1 is ignored; fault_clr with start=0 and fault=0 goes to IDLE and clears fault_latched.
- Apply resetn=0 for one edge mid-SOFTSTART. Required: all outputs at reset values (freq_cmd=0110, dt cmds=001) on that edge.
- With PWM_WATCHDOG_EN, WDOG_CYCLES=16: stop period_end in RUN. Fault latches on the 16th cycle after the last period_end. Without the macro, the state stays RUN indefinitely.
